// File: rtl/pcie_rq_inv_cpl_merge.sv
// Merges snooped Invalidation Completion beats (via a small FIFO) with the user RQ stream.
// Optional statistics counters are enabled by defining PCIE_RQ_MERGE_STATS_EN.
module pcie_rq_inv_cpl_merge #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 137,
  parameter int CPL_FIFO_DEPTH   = 8,
  parameter int MAX_CPL_BURST    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [AXIS_DATA_WIDTH-1:0]        s_cpl_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]      s_cpl_tkeep,
  input  logic                              s_cpl_tvalid,
  input  logic                              s_cpl_tlast,
  output logic                              s_cpl_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        s_usr_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]      s_usr_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]       s_usr_tuser,
  input  logic                              s_usr_tlast,
  input  logic                              s_usr_tvalid,
  output logic                              s_usr_tready,
  output logic [AXIS_DATA_WIDTH-1:0]        m_rq_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]      m_rq_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]       m_rq_tuser,
  output logic                              m_rq_tlast,
  output logic                              m_rq_tvalid,
  input  logic                              m_rq_tready,
  output logic [$clog2(CPL_FIFO_DEPTH):0]   cpl_fifo_level,
  output logic                              cpl_protocol_err
`ifdef PCIE_RQ_MERGE_STATS_EN
  ,
  output logic [15:0]                       stat_cpl_sent,
  output logic [15:0]                       stat_usr_pkts,
  output logic [15:0]                       stat_cpl_full_cycles
`endif
);

  localparam int KW = AXIS_DATA_WIDTH / 8;
  localparam int PW = $clog2(CPL_FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(MAX_CPL_BURST + 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(CPL_FIFO_DEPTH);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_CPL_BURST);

  typedef enum logic {IDLE, USR_LOCK} state_e;
  typedef enum logic [1:0] {GNT_NONE = 2'b00, GNT_CPL = 2'b01, GNT_USR = 2'b10} grant_e;

  logic [AXIS_DATA_WIDTH-1:0] data_mem [CPL_FIFO_DEPTH];
  logic [KW-1:0]              keep_mem [CPL_FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]              level_q, level_d;
  logic                       cpl_rdy_q, err_q;
  state_e                     state_q, state_d;
  grant_e                     grant_q, grant_d;
  logic [BW-1:0]              burst_q, burst_d;
  logic                       cpl_push, fifo_vld, cpl_hs, usr_hs, usr_req, cpl_req;

  assign cpl_push         = s_cpl_tvalid & cpl_rdy_q;
  assign fifo_vld         = (level_q != '0);
  assign cpl_hs           = (grant_q == GNT_CPL) & m_rq_tvalid & m_rq_tready;
  assign usr_hs           = (grant_q == GNT_USR) & m_rq_tvalid & m_rq_tready;
  assign level_d          = level_q + LW'(cpl_push) - LW'(cpl_hs);
  assign s_cpl_tready     = cpl_rdy_q;
  assign cpl_fifo_level   = level_q;
  assign cpl_protocol_err = err_q;

  always_ff @(posedge clk) begin
    if (cpl_push) begin
      data_mem[wr_ptr_q] <= s_cpl_tdata;
      keep_mem[wr_ptr_q] <= s_cpl_tkeep;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      cpl_rdy_q <= 1'b0;
      err_q     <= 1'b0;
      state_q   <= IDLE;
      grant_q   <= GNT_NONE;
      burst_q   <= '0;
    end else begin
      if (cpl_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (cpl_hs)   rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q   <= level_d;
      cpl_rdy_q <= (level_d != FULL_LVL);
      if (cpl_push && !s_cpl_tlast) err_q <= 1'b1;
      state_q   <= state_d;
      grant_q   <= grant_d;
      burst_q   <= burst_d;
    end
  end

  // Arbitration looks at next-cycle FIFO occupancy so a freshly pushed completion
  // is granted in the following cycle; a user beat consumed now no longer requests.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    burst_d = burst_q;
    if (cpl_hs && burst_q != BURST_MAX) burst_d = burst_q + BW'(1);
    if (usr_hs && s_usr_tlast)          burst_d = '0;
    usr_req = s_usr_tvalid & ~usr_hs;
    cpl_req = (level_d != '0);
    case (state_q)
      USR_LOCK: begin
        grant_d = GNT_USR;
        if (usr_hs && s_usr_tlast) state_d = IDLE;
      end
      default: begin
        if (usr_hs && !s_usr_tlast) begin
          state_d = USR_LOCK;
          grant_d = GNT_USR;
        end
      end
    endcase
    if (state_d == IDLE && !(m_rq_tvalid && !m_rq_tready)) begin
      if (cpl_req && (burst_d < BURST_MAX || !usr_req)) grant_d = GNT_CPL;
      else if (usr_req)                                 grant_d = GNT_USR;
      else                                              grant_d = GNT_NONE;
    end
  end

  always_comb begin
    m_rq_tdata   = '0;
    m_rq_tkeep   = '0;
    m_rq_tuser   = '0;
    m_rq_tlast   = 1'b0;
    m_rq_tvalid  = 1'b0;
    s_usr_tready = 1'b0;
    case (grant_q)
      GNT_CPL: begin
        m_rq_tdata  = data_mem[rd_ptr_q];
        m_rq_tkeep  = keep_mem[rd_ptr_q];
        m_rq_tlast  = 1'b1;
        m_rq_tvalid = fifo_vld;
      end
      GNT_USR: begin
        m_rq_tdata   = s_usr_tdata;
        m_rq_tkeep   = s_usr_tkeep;
        m_rq_tuser   = s_usr_tuser;
        m_rq_tlast   = s_usr_tlast;
        m_rq_tvalid  = s_usr_tvalid;
        s_usr_tready = m_rq_tready;
      end
      default: ;
    endcase
  end

`ifdef PCIE_RQ_MERGE_STATS_EN
  logic [15:0] st_cpl_q, st_usr_q, st_full_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_cpl_q  <= '0;
      st_usr_q  <= '0;
      st_full_q <= '0;
    end else begin
      if (cpl_hs && st_cpl_q != '1)                 st_cpl_q  <= st_cpl_q + 16'd1;
      if (usr_hs && s_usr_tlast && st_usr_q != '1)  st_usr_q  <= st_usr_q + 16'd1;
      if (s_cpl_tvalid && !cpl_rdy_q && st_full_q != '1) st_full_q <= st_full_q + 16'd1;
    end
  end

  assign stat_cpl_sent        = st_cpl_q;
  assign stat_usr_pkts        = st_usr_q;
  assign stat_cpl_full_cycles = st_full_q;
`endif

endmodule

// File: tb/tb_pcie_rq_inv_cpl_merge.sv
// Directed self-checking bench for pcie_rq_inv_cpl_merge (default parameters).
module tb_pcie_rq_inv_cpl_merge;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] s_cpl_tdata;
  logic [63:0]  s_cpl_tkeep;
  logic         s_cpl_tvalid, s_cpl_tlast, s_cpl_tready;
  logic [511:0] s_usr_tdata;
  logic [63:0]  s_usr_tkeep;
  logic [136:0] s_usr_tuser;
  logic         s_usr_tlast, s_usr_tvalid, s_usr_tready;
  logic [511:0] m_rq_tdata;
  logic [63:0]  m_rq_tkeep;
  logic [136:0] m_rq_tuser;
  logic         m_rq_tlast, m_rq_tvalid, m_rq_tready;
  logic [3:0]   cpl_fifo_level;
  logic         cpl_protocol_err;

  int unsigned  n_chk = 0;
  int unsigned  n_fail = 0;
  int unsigned  cyc = 0;
  logic [31:0]  obs_q[$];
  int unsigned  obs_cyc[$];

  pcie_rq_inv_cpl_merge #(
    .AXIS_DATA_WIDTH (512),
    .AXIS_TUSER_WIDTH(137),
    .CPL_FIFO_DEPTH  (8),
    .MAX_CPL_BURST   (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_cpl_tdata     (s_cpl_tdata),
    .s_cpl_tkeep     (s_cpl_tkeep),
    .s_cpl_tvalid    (s_cpl_tvalid),
    .s_cpl_tlast     (s_cpl_tlast),
    .s_cpl_tready    (s_cpl_tready),
    .s_usr_tdata     (s_usr_tdata),
    .s_usr_tkeep     (s_usr_tkeep),
    .s_usr_tuser     (s_usr_tuser),
    .s_usr_tlast     (s_usr_tlast),
    .s_usr_tvalid    (s_usr_tvalid),
    .s_usr_tready    (s_usr_tready),
    .m_rq_tdata      (m_rq_tdata),
    .m_rq_tkeep      (m_rq_tkeep),
    .m_rq_tuser      (m_rq_tuser),
    .m_rq_tlast      (m_rq_tlast),
    .m_rq_tvalid     (m_rq_tvalid),
    .m_rq_tready     (m_rq_tready),
    .cpl_fifo_level  (cpl_fifo_level),
    .cpl_protocol_err(cpl_protocol_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output handshakes, captured on the falling edge preceding the accepting edge.
  always @(negedge clk) begin
    if (rst && m_rq_tvalid && m_rq_tready) begin
      obs_q.push_back(m_rq_tdata[31:0]);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cpl(input logic [31:0] d, input logic last);
    bit done = 0;
    s_cpl_tdata       = '0;
    s_cpl_tdata[31:0] = d;
    s_cpl_tkeep       = '1;
    s_cpl_tlast       = last;
    s_cpl_tvalid      = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (s_cpl_tready) done = 1;
      @(posedge clk);
      #1;
    end
    s_cpl_tvalid = 1'b0;
    if (!done) check("cpl_push_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_usr_beat(input logic [31:0] d, input logic last);
    bit done = 0;
    s_usr_tdata        = '0;
    s_usr_tdata[31:0]  = d;
    s_usr_tkeep        = '1;
    s_usr_tuser        = '0;
    s_usr_tuser[15:0]  = d[15:0];
    s_usr_tlast        = last;
    s_usr_tvalid       = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (s_usr_tready) done = 1;
      @(posedge clk);
      #1;
    end
    s_usr_tvalid = 1'b0;
    if (!done) check("usr_beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_usr_pkt(input logic [31:0] base, input int beats);
    for (int b = 0; b < beats; b++)
      send_usr_beat(base + 32'(b), (b == beats - 1));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    obs_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    logic [31:0] exp_seq[$];
    rst          = 1'b0;
    s_cpl_tdata  = '0;
    s_cpl_tkeep  = '0;
    s_cpl_tvalid = 1'b0;
    s_cpl_tlast  = 1'b1;
    s_usr_tdata  = '0;
    s_usr_tkeep  = '0;
    s_usr_tuser  = '0;
    s_usr_tlast  = 1'b0;
    s_usr_tvalid = 1'b0;
    m_rq_tready  = 1'b1;

    // Reset state
    tick(3);
    @(negedge clk);
    check("rst_m_tvalid", m_rq_tvalid, 0);
    check("rst_usr_tready", s_usr_tready, 0);
    check("rst_cpl_tready", s_cpl_tready, 0);
    check("rst_level", cpl_fifo_level, 0);
    check("rst_err", cpl_protocol_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(2);

    // Single completion, one-cycle latency
    s_cpl_tdata       = '0;
    s_cpl_tdata[31:0] = 32'h30;
    s_cpl_tkeep       = '1;
    s_cpl_tlast       = 1'b1;
    s_cpl_tvalid      = 1'b1;
    @(negedge clk);
    check("t1_cpl_tready", s_cpl_tready, 1);
    check("t1_not_yet_valid", m_rq_tvalid, 0);
    @(posedge clk); #1;
    s_cpl_tvalid = 1'b0;
    @(negedge clk);
    check("t1_m_tvalid", m_rq_tvalid, 1);
    check("t1_m_tdata", m_rq_tdata[63:0], 64'h30);
    check("t1_m_tlast", m_rq_tlast, 1);
    check("t1_m_tuser_zero", (m_rq_tuser == '0), 1);
    check("t1_level1", cpl_fifo_level, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_level0", cpl_fifo_level, 0);
    check("t1_m_tvalid_low", m_rq_tvalid, 0);
    check("t1_out_count", obs_q.size(), 1);
    tick(2);
    obs_q.delete(); obs_cyc.delete();

    // 3-beat user packet; completion arrives during beat 2 and must follow the packet
    fork
      send_usr_pkt(32'h200, 3);
      begin
        tick(1);
        send_cpl(32'h131, 1'b1);
      end
    join
    tick(6);
    exp_seq = '{32'h200, 32'h201, 32'h202, 32'h131};
    check("t2_count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++)
      check($sformatf("t2_order%0d", i), obs_q[i], exp_seq[i]);
    if (obs_cyc.size() >= 3) begin
      check("t2_contig01", obs_cyc[1] - obs_cyc[0], 1);
      check("t2_contig12", obs_cyc[2] - obs_cyc[1], 1);
    end
    obs_q.delete(); obs_cyc.delete();

    // Fill FIFO under backpressure, then drain in order
    m_rq_tready = 1'b0;
    for (int i = 0; i < 8; i++) send_cpl(32'h140 + 32'(i), 1'b1);
    @(negedge clk);
    check("t3_level_full", cpl_fifo_level, 8);
    check("t3_cpl_tready_full", s_cpl_tready, 0);
    check("t3_head_valid", m_rq_tvalid, 1);
    check("t3_head_data", m_rq_tdata[63:0], 64'h140);
    @(posedge clk); #1;
    m_rq_tready = 1'b1;
    tick(12);
    check("t3_count", obs_q.size(), 8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++)
      check($sformatf("t3_order%0d", i), obs_q[i], 32'h140 + 32'(i));
    check("t3_level_empty", cpl_fifo_level, 0);
    obs_q.delete(); obs_cyc.delete();

    // Backpressure stability
    m_rq_tready = 1'b0;
    send_cpl(32'h150, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t5_valid%0d", i), m_rq_tvalid, 1);
      check($sformatf("t5_data%0d", i), m_rq_tdata[63:0], 64'h150);
      check($sformatf("t5_level%0d", i), cpl_fifo_level, 1);
    end
    @(posedge clk); #1;
    m_rq_tready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_popped", cpl_fifo_level, 0);
    check("t5_count", obs_q.size(), 1);
    tick(2);

    // Starvation bound: 6 completions vs one waiting user beat
    do_reset();
    m_rq_tready = 1'b0;
    for (int i = 0; i < 6; i++) send_cpl(32'h160 + 32'(i), 1'b1);
    fork
      send_usr_beat(32'h260, 1'b1);
      begin
        tick(2);
        m_rq_tready = 1'b1;
      end
    join
    tick(10);
    exp_seq = '{32'h160, 32'h161, 32'h162, 32'h163, 32'h260, 32'h164, 32'h165};
    check("t4_count", obs_q.size(), 7);
    for (int i = 0; i < 7 && i < obs_q.size(); i++)
      check($sformatf("t4_order%0d", i), obs_q[i], exp_seq[i]);

    // Reset while locked on a user packet with completions queued
    m_rq_tready = 1'b1;
    send_usr_beat(32'h270, 1'b0);
    for (int i = 0; i < 3; i++) send_cpl(32'h180 + 32'(i), 1'b1);
    @(negedge clk);
    check("t6_level3", cpl_fifo_level, 3);
    check("t6_locked_no_cpl", m_rq_tvalid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_rst_tvalid", m_rq_tvalid, 0);
    check("t6_rst_level", cpl_fifo_level, 0);
    check("t6_rst_cpl_tready", s_cpl_tready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(2);
    obs_q.delete(); obs_cyc.delete();
    check("t6_err_clear", cpl_protocol_err, 0);
    send_cpl(32'h170, 1'b0);
    @(negedge clk);
    check("t6_err_set", cpl_protocol_err, 1);
    tick(4);
    check("t6_idle_count", obs_q.size(), 1);
    if (obs_q.size() > 0) check("t6_idle_data", obs_q[0], 32'h170);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_rq_inv_cpl_merge.md
Name: pcie_rq_inv_cpl_merge

Overview:
- Sits downstream of the CQ ATS snooper, between it and the PCIe hard-block RQ interface.
- Buffers single-beat Invalidation Completion TLPs from the snooper in a small FIFO so none are lost.
- Merges them with the user RQ stream onto one RQ AXI-stream master.
- Arbitrates only at packet boundaries and never splits a multi-beat user packet.

Parameters:
AXIS_DATA_WIDTH, 512, RQ tdata width; tkeep is AXIS_DATA_WIDTH/8 (64 at default)
AXIS_TUSER_WIDTH, 137, RQ tuser width
CPL_FIFO_DEPTH, 8, completion FIFO entries; power of two, at least 2
MAX_CPL_BURST, 4, maximum consecutive completions granted while a user packet is waiting

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
s_cpl_tdata  in  AXIS_DATA_WIDTH  completion beat from snooper
s_cpl_tkeep  in  AXIS_DATA_WIDTH/8  completion keep
s_cpl_tvalid  in  1  completion valid
s_cpl_tlast  in  1  must be 1; checked only
s_cpl_tready  out  1  high when completion FIFO not full
s_usr_tdata  in  AXIS_DATA_WIDTH  user RQ data
s_usr_tkeep  in  AXIS_DATA_WIDTH/8  user RQ keep
s_usr_tuser  in  AXIS_TUSER_WIDTH  user RQ tuser
s_usr_tlast  in  1  user RQ last
s_usr_tvalid  in  1  user RQ valid
s_usr_tready  out  1  user RQ ready
m_rq_tdata  out  AXIS_DATA_WIDTH  merged RQ data
m_rq_tkeep  out  AXIS_DATA_WIDTH/8  merged RQ keep
m_rq_tuser  out  AXIS_TUSER_WIDTH  merged RQ tuser; all zero on completion beats
m_rq_tlast  out  1  merged RQ last; 1 on completion beats
m_rq_tvalid  out  1  merged RQ valid
m_rq_tready  in  1  hard-block ready
cpl_fifo_level  out  $clog2(CPL_FIFO_DEPTH)+1  current FIFO occupancy
cpl_protocol_err  out  1  sticky; set when a completion is accepted with s_cpl_tlast=0

Behaviour:
- Reset (rst=0 at clk edge): FIFO flushed, state IDLE, burst_cnt=0, cpl_protocol_err=0.
  - Outputs: m_rq_tvalid=0, s_usr_tready=0, s_cpl_tready=0, cpl_fifo_level=0.
  - A reset mid-packet drops the packet; the user source must restart it.
- Completion FIFO:
  - Push on s_cpl_tvalid & s_cpl_tready; it stores tdata and tkeep.
  - s_cpl_tready = !full, registered from occupancy; no bypass, so it is 0 when full even during a pop.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo CPL_FIFO_DEPTH. Minimum input-to-m_rq_tvalid latency is 1 cycle.
- Grant:
  - Grant is a registered 2-bit one-hot, NONE/CPL/USR.
  - m_rq_* are muxed from the granted source, and only the granted source sees m_rq_tready.
  - A grant with m_rq_tvalid=1 and m_rq_tready=0 holds unchanged, per AXI stability.
- FSM state IDLE (no beat pending or last beat accepted):
  - If the FIFO is non-empty and (burst_cnt<MAX_CPL_BURST or s_usr_tvalid=0): grant CPL.
  - Else if s_usr_tvalid: grant USR.
  - Else: NONE.
  - A CPL handshake pops the FIFO, burst_cnt++ (saturating), and the FSM stays in IDLE.
  - A USR handshake with tlast=1 clears burst_cnt and stays in IDLE.
  - A USR handshake with tlast=0 moves to USR_LOCK.
  - USR is still granted when s_usr_tvalid=0 inside USR_LOCK; there is no timeout.
- FSM state USR_LOCK: only USR is granted. Completions accumulate in the FIFO. A USR handshake with tlast=1 clears burst_cnt and returns to IDLE.
- Simultaneous requests in IDLE with burst_cnt<MAX_CPL_BURST: completion wins.
- Starvation bound: a waiting user packet is delayed at most MAX_CPL_BURST completion beats.

Optional Feature:
- Macro: PCIE_RQ_MERGE_STATS_EN.
- When defined, three extra output ports are added, each 16 bits, saturating at 0xFFFF and cleared by reset:
  - stat_cpl_sent: completion handshakes.
  - stat_usr_pkts: user tlast handshakes.
  - stat_cpl_full_cycles: cycles with s_cpl_tvalid=1 and s_cpl_tready=0.
- When not defined, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Single completion, tdata 0x..30, m_rq_tready=1, user idle -> m_rq_tvalid on cycle+1, tlast=1, tuser=0, level returns 0.
- User 3-beat packet, with a completion arriving on beat 2 -> three user beats contiguous, then the completion; no interleave.
- 8 completions back-to-back with m_rq_tready=0 -> level=8, s_cpl_tready=0; release ready -> 8 beats out in order.
- 6 completions queued plus user single-beat pending, MAX_CPL_BURST=4 -> order cpl×4, usr, cpl×2.
- Backpressure: m_rq_tready low for 5 cycles while a completion is presented -> data and grant stable, no pop until handshake.
- Reset asserted in USR_LOCK with FIFO level 3 -> next cycle m_rq_tvalid=0, level=0, state IDLE; completion accepted with tlast=0 -> cpl_protocol_err=1.
